// File: rtl/output_port_arbiter.sv
// output_port_arbiter: round-robin wormhole arbiter draining per-input FIFOs onto one output link
// under credit-based flow control, holding the grant for a whole packet.
module output_port_arbiter #(
  parameter  int NUM_BUFFERS = 4,
  parameter  int CREDITS     = 8,
  parameter  int LEN_LSB     = 0,
  parameter  int LEN_W       = 4,
  parameter  int FLIT_W      = 16,
  localparam int CW          = $clog2(CREDITS + 1),
  localparam int GW          = $clog2(NUM_BUFFERS)
) (
  input  logic                                CLK,
  input  logic                                nRST,
  input  logic [NUM_BUFFERS-1:0]              empty,
  input  logic [NUM_BUFFERS-1:0][FLIT_W-1:0]  rdata,
  input  logic [NUM_BUFFERS-1:0]              route_match,
  output logic [NUM_BUFFERS-1:0]              REN,
  output logic                                out_valid,
  output logic [FLIT_W-1:0]                   out_flit,
  input  logic                                credit_return,
  output logic [CW-1:0]                       credits,
  output logic                                busy,
  output logic [GW-1:0]                       grant_id,
  output logic                                credit_err
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam logic [LEN_W:0] REM_ONE = 1;
  logic [0:0]             state_q, state_d;
  logic [GW-1:0]          grant_q, grant_d, rr_sel;
  logic [LEN_W:0]         rem_q, rem_d;
  logic [CW-1:0]          cred_q, cred_d;
  logic                   out_valid_q;
  logic [FLIT_W-1:0]      out_flit_q;
  logic                   err_q;
  logic [NUM_BUFFERS-1:0] req;
  logic                   rr_found, fire, sat;
  assign req = ~empty & route_match;
  // Scan downward so the last hit is the nearest requester after the pointer.
  always_comb begin
    rr_found = 1'b0;
    rr_sel = grant_q;
    for (int k = NUM_BUFFERS; k >= 1; k--) begin
      if (req[(int'(grant_q) + k) % NUM_BUFFERS]) begin
        rr_found = 1'b1;
        rr_sel = GW'((int'(grant_q) + k) % NUM_BUFFERS);
      end
    end
  end
  assign fire = (state_q == SEND) && !empty[grant_q] && (cred_q != '0);
  assign sat  = credit_return && !fire && (cred_q == CW'(CREDITS));
  always_comb begin
    REN = '0;
    REN[grant_q] = fire;
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rem_d = rem_q;
    if (state_q == IDLE && rr_found) begin
      state_d = SEND;
      grant_d = rr_sel;
      rem_d = {1'b0, rdata[rr_sel][LEN_LSB +: LEN_W]} + REM_ONE;
    end else if (fire) begin
      rem_d = rem_q - REM_ONE;
      state_d = (rem_q == REM_ONE) ? IDLE : SEND;
    end
  end
  assign cred_d = sat ? cred_q : cred_q - CW'(fire) + CW'(credit_return);
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      grant_q <= GW'(NUM_BUFFERS - 1);
      rem_q <= '0;
      cred_q <= CW'(CREDITS);
      out_valid_q <= 1'b0;
      out_flit_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rem_q <= rem_d;
      cred_q <= cred_d;
      out_valid_q <= fire;
      if (fire) out_flit_q <= rdata[grant_q];
      err_q <= err_q | sat;
    end
  end
  assign out_valid  = out_valid_q;
  assign out_flit   = out_flit_q;
  assign credits    = cred_q;
  assign busy       = (state_q == SEND);
  assign grant_id   = grant_q;
  assign credit_err = err_q;
endmodule

// File: doc/output_port_arbiter.md
Name: output_port_arbiter

Overview:
Per-output-port wormhole arbiter that drains the switch's input FIFO bank (one FIFO per input port) toward a single output link. Selects among input FIFOs whose head flit is routed to this output using round-robin. Holds the grant for the whole packet, with the length taken from the head flit. Forwards flits under credit-based flow control from the downstream receiver.

Parameters:
NUM_BUFFERS, 4, number of input FIFOs competing for this output (>=2)
CREDITS, 8, downstream receiver buffer depth; initial/maximum credit count
LEN_LSB, 0, bit position of payload-length field in head flit
LEN_W, 4, width of payload-length field (payload flits following head, 0..2^LEN_W-1)

Ports:
CLK  input  1  clock
nRST  input  1  asynchronous active-low reset
empty  input  NUM_BUFFERS  per-FIFO empty flag
rdata  input  NUM_BUFFERS x flit_t  per-FIFO head-of-queue flit
route_match  input  NUM_BUFFERS  routing stage: FIFO i head flit targets this output (valid only when not empty and FIFO idle)
REN  output  NUM_BUFFERS  per-FIFO pop strobe, combinational, at most one bit high
out_valid  output  1  registered: out_flit valid this cycle
out_flit  output  flit_t  registered forwarded flit
credit_return  input  1  downstream freed one slot (one credit per cycle max)
credits  output  $clog2(CREDITS+1)  current credit count
busy  output  1  packet in progress (state SEND)
grant_id  output  $clog2(NUM_BUFFERS)  currently/last granted FIFO
credit_err  output  1  sticky: credit_return while credits==CREDITS

Behaviour:
- Reset (async, nRST low): state IDLE, out_valid=0, out_flit=0, credits=CREDITS, grant_id=NUM_BUFFERS-1 (so FIFO 0 has first priority), remaining=0, credit_err=0; REN=0 (comb, follows state).
- States: IDLE, SEND.
- IDLE: req[i] = !empty[i] && route_match[i]. If any req, grant first requester searching from grant_id+1 upward, modulo NUM_BUFFERS. Register grant_id=g and remaining = rdata[g][LEN_LSB+:LEN_W] + 1 (head included, width LEN_W+1). Go SEND next cycle. No pop in IDLE.
- SEND: fire = !empty[g] && credits!=0. On fire: REN[g]=1 same cycle; next cycle out_valid=1, out_flit=rdata[g] captured at fire; remaining decrements. On a fire with remaining==1: return to IDLE; grant_id stays g, which becomes the round-robin pointer.
- No fire: REN=0, out_valid=0 next cycle, grant held. A FIFO emptying mid-packet stalls; it never releases the grant.
- Minimum arbitration gap: one IDLE cycle between packets. Throughput: one flit/cycle while credits and data are available.
- Credits: next = credits - fire + credit_return. A simultaneous fire and return leaves credits unchanged. A return at credits==CREDITS without fire saturates at CREDITS and sets credit_err, cleared only by reset.
- Fire is evaluated with the current-cycle credits. A return in the same cycle does not enable a fire at credits==0.
- Length field 0: single-flit packet, IDLE->SEND->IDLE with one fire.
- route_match and req for non-granted FIFOs are ignored during SEND.
- Reset asserted mid-packet: immediate return to reset values. Any partially sent packet is abandoned; upstream/downstream recovery is out of scope.

Test Plan:
- FIFO 1 only, head len=3, CREDITS=8 -> grant_id=1 one cycle after request; REN[1] high 4 consecutive cycles; out_valid 4 cycles lagging by 1; credits 8->4; busy drops after 4th flit.
- FIFOs 0,2,3 all requesting single-flit packets after reset -> grant order 0,2,3,0 with one IDLE cycle between each.
- CREDITS=2, 5-flit packet, no returns -> 2 flits sent, then REN=0 stall with busy=1; pulse credit_return 3 times -> remaining 3 flits sent; credits ends 0.
- FIFO granted with 4-flit packet empties after flit 2 for 3 cycles -> no REN, no out_valid, grant_id unchanged, other requesters not granted; resumes on refill.
- credit_return pulsed at credits=8 -> credits stays 8, credit_err=1 and stays 1. Simultaneous fire+return at credits=3 -> credits stays 3.
- nRST asserted after flit 2 of a 6-flit packet -> next cycle busy=0, out_valid=0, credits=CREDITS, grant_id=NUM_BUFFERS-1.
